// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the accumulator-CPU control sequencer.
package ctrl_pkg;

  localparam int unsigned IR_W   = 9;
  localparam int unsigned FUNC_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    HALT   = 3'd5
  } state_t;

  // OP=0 function codes
  localparam logic [FUNC_W-1:0] F_ADD  = 4'b0000;
  localparam logic [FUNC_W-1:0] F_MOV  = 4'b0001;
  localparam logic [FUNC_W-1:0] F_HALT = 4'b0010;
  localparam logic [FUNC_W-1:0] F_SUB  = 4'b0011;
  localparam logic [FUNC_W-1:0] F_AND  = 4'b0100;
  localparam logic [FUNC_W-1:0] F_OR   = 4'b0101;
  localparam logic [FUNC_W-1:0] F_SLL  = 4'b0110;
  localparam logic [FUNC_W-1:0] F_SRL  = 4'b0111;
  localparam logic [FUNC_W-1:0] F_XOR  = 4'b1000;
  localparam logic [FUNC_W-1:0] F_NOT  = 4'b1001;
  localparam logic [FUNC_W-1:0] F_BEZR = 4'b1010;
  localparam logic [FUNC_W-1:0] F_SW   = 4'b1011;
  localparam logic [FUNC_W-1:0] F_LW   = 4'b1100;

  // OP=1 function codes (ir[7:6])
  localparam logic [1:0] F_SETI = 2'b00;
  localparam logic [1:0] F_SLIZ = 2'b01;
  localparam logic [1:0] F_SLTI = 2'b10;

  // ALU Zero branch codes
  localparam logic [1:0] ZERO_FWD = 2'b01;
  localparam logic [1:0] ZERO_BWD = 2'b10;

  typedef struct packed {
    logic acc_we;
    logic rf_we;
    logic dmem_we;
    logic dmem_re;
    logic carry_upd;
    logic branch;
    logic lw;
    logic halt;
    logic illegal;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: ir -> EXEC-cycle enables and control flags.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  output dec_t            dec
);

  always_comb begin
    dec = '0;
    if (ir[8]) begin
      // Immediate group: seti/sliz/slti write the accumulator, 11 is undefined
      if (ir[7:6] == 2'b11) dec.illegal = 1'b1;
      else                  dec.acc_we  = 1'b1;
    end else begin
      case (ir[7:4])
        F_ADD, F_SLL: begin
          dec.acc_we    = 1'b1;
          dec.carry_upd = 1'b1;
        end
        F_SUB, F_AND, F_OR, F_SRL, F_XOR, F_NOT: dec.acc_we = 1'b1;
        F_MOV:  dec.rf_we   = 1'b1;
        F_HALT: dec.halt    = 1'b1;
        F_BEZR: dec.branch  = 1'b1;
        F_SW:   dec.dmem_we = 1'b1;
        F_LW: begin
          dec.dmem_re = 1'b1;
          dec.lw      = 1'b1;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: fetch/decode/exec FSM, PC and carry registers.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned     PC_W   = 8,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_data,
  output logic            alu_op,
  output logic [3:0]      alu_func,
  output logic            alu_dsel,
  output logic [3:0]      rf_idx,
  output logic [5:0]      imm6,
  input  logic [7:0]      alu_out,
  input  logic [1:0]      alu_zero,
  input  logic            alu_carry,
  output logic            acc_we,
  output logic            rf_we,
  output logic            wb_sel,
  output logic            dmem_we,
  output logic            dmem_re,
  output logic            carry_flag,
  output logic            halted,
  output logic            illegal
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            carry_q, carry_d;
  dec_t            dec;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_off;

  ctrl_decode u_decode (
    .ir  (ir_q),
    .dec (dec)
  );

  // ALU field selects straight from the instruction register
  assign alu_op     = ir_q[8];
  assign alu_func   = ir_q[8] ? {2'b00, ir_q[7:6]} : ir_q[7:4];
  assign alu_dsel   = ir_q[8];
  assign rf_idx     = ir_q[3:0];
  assign imm6       = ir_q[5:0];
  assign imem_addr  = pc_q;
  assign carry_flag = carry_q;

  assign pc_inc = pc_q + PC_W'(1);
  assign br_off = PC_W'(alu_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RST_PC;
      ir_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
    end
  end

  // Enables derive from the registered state, so reset drops them at once
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    carry_d = carry_q;
    acc_we  = 1'b0;
    rf_we   = 1'b0;
    wb_sel  = 1'b0;
    dmem_we = 1'b0;
    dmem_re = 1'b0;
    halted  = 1'b0;
    illegal = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        ir_d    = imem_data;
        state_d = EXEC;
      end
      EXEC: begin
        acc_we  = dec.acc_we;
        rf_we   = dec.rf_we;
        dmem_we = dec.dmem_we;
        dmem_re = dec.dmem_re;
        illegal = dec.illegal;
        if (dec.carry_upd) carry_d = alu_carry;
        if (dec.halt) begin
          state_d = HALT;
        end else if (dec.lw) begin
          state_d = MEM;
        end else begin
          state_d = FETCH;
          if (dec.branch) begin
            case (alu_zero)
              ZERO_FWD: pc_d = pc_q + br_off;
              ZERO_BWD: pc_d = pc_q - br_off;
              default:  pc_d = pc_inc;
            endcase
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      MEM: begin
        acc_we  = 1'b1;
        wb_sel  = 1'b1;
        pc_d    = pc_inc;
        state_d = FETCH;
      end
      HALT: halted = 1'b1;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed self-checking bench for ctrl_seq with a synchronous instruction memory model.
module tb_ctrl_seq;
  import ctrl_pkg::*;

  localparam int unsigned PC_W = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [PC_W-1:0] imem_addr;
  logic [8:0]      imem_data;
  logic            alu_op;
  logic [3:0]      alu_func;
  logic            alu_dsel;
  logic [3:0]      rf_idx;
  logic [5:0]      imm6;
  logic [7:0]      alu_out;
  logic [1:0]      alu_zero;
  logic            alu_carry;
  logic            acc_we, rf_we, wb_sel, dmem_we, dmem_re;
  logic            carry_flag, halted, illegal;

  logic [8:0] mem [256];
  int n_tests = 0;
  int n_fail  = 0;

  ctrl_seq #(.PC_W(PC_W), .RST_PC(8'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr),
    .imem_data(imem_data), .alu_op(alu_op), .alu_func(alu_func),
    .alu_dsel(alu_dsel), .rf_idx(rf_idx), .imm6(imm6), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .acc_we(acc_we),
    .rf_we(rf_we), .wb_sel(wb_sel), .dmem_we(dmem_we), .dmem_re(dmem_re),
    .carry_flag(carry_flag), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (3 * n) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 9'b0_0011_0000;
    mem[0]  = 9'b0_0000_0011;  // add r3
    mem[5]  = 9'b0_1100_0010;  // lw
    mem[6]  = 9'b0_1110_0000;  // illegal
    mem[7]  = 9'b1_00_000101;  // seti 5
    mem[8]  = 9'b0_1011_0000;  // sw
    mem[10] = 9'b0_1010_0000;  // bezr
    mem[11] = 9'b0_0001_0101;  // mov r5
    mem[12] = 9'b0_1010_0000;  // bezr
    mem[13] = 9'b0_1011_0000;  // sw
    rst_n = 1'b0; start = 1'b0; alu_out = 8'd0; alu_zero = 2'b00; alu_carry = 1'b0;
    tick(); tick();

    chk("rst_addr",    32'(imem_addr), 32'd0);
    chk("rst_state",   32'(dut.state_q), 32'(IDLE));
    chk("rst_halted",  32'(halted), 32'd0);
    chk("rst_acc_we",  32'(acc_we), 32'd0);
    chk("rst_carry",   32'(carry_flag), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);

    rst_n = 1'b1;
    tick();
    chk("idle_hold", 32'(dut.state_q), 32'(IDLE));

    start = 1'b1;
    tick();                                 // FETCH pc=0
    start = 1'b0;
    chk("c1_state",  32'(dut.state_q), 32'(FETCH));
    chk("c1_acc_we", 32'(acc_we), 32'd0);
    tick();                                 // DECODE
    chk("c2_acc_we", 32'(acc_we), 32'd0);
    tick();                                 // EXEC add r3
    alu_carry = 1'b1;
    chk("add_acc_we", 32'(acc_we), 32'd1);
    chk("add_wb_sel", 32'(wb_sel), 32'd0);
    chk("add_func",   32'(alu_func), 32'd0);
    chk("add_rf_idx", 32'(rf_idx), 32'd3);
    chk("add_dsel",   32'(alu_dsel), 32'd0);
    chk("add_carry_pre", 32'(carry_flag), 32'd0);
    tick();                                 // FETCH pc=1
    chk("add_pc",     32'(imem_addr), 32'd1);
    chk("add_carry",  32'(carry_flag), 32'd1);
    chk("add_acc_off", 32'(acc_we), 32'd0);

    alu_carry = 1'b0;
    run(4);                                 // pc 1..4 -> FETCH pc=5
    chk("pc5",        32'(imem_addr), 32'd5);
    chk("carry_hold", 32'(carry_flag), 32'd1);

    tick(); tick();                         // EXEC lw
    chk("lw_dmem_re", 32'(dmem_re), 32'd1);
    chk("lw_acc_we0", 32'(acc_we), 32'd0);
    tick();                                 // MEM
    chk("mem_acc_we", 32'(acc_we), 32'd1);
    chk("mem_wb_sel", 32'(wb_sel), 32'd1);
    chk("mem_re_off", 32'(dmem_re), 32'd0);
    chk("mem_pc",     32'(imem_addr), 32'd5);
    tick();                                 // FETCH pc=6
    chk("lw_pc",      32'(imem_addr), 32'd6);

    tick(); tick();                         // EXEC illegal
    chk("ill_pulse",  32'(illegal), 32'd1);
    chk("ill_en", 32'({acc_we, rf_we, dmem_we, dmem_re}), 32'd0);
    tick();
    chk("ill_clear",  32'(illegal), 32'd0);
    chk("ill_pc",     32'(imem_addr), 32'd7);

    tick(); tick();                         // EXEC seti 5
    chk("seti_op",    32'(alu_op), 32'd1);
    chk("seti_func",  32'(alu_func), 32'd0);
    chk("seti_dsel",  32'(alu_dsel), 32'd1);
    chk("seti_imm",   32'(imm6), 32'd5);
    chk("seti_acc",   32'(acc_we), 32'd1);
    tick();                                 // FETCH pc=8

    tick(); tick();                         // EXEC sw
    chk("sw_we",      32'(dmem_we), 32'd1);
    tick();
    chk("sw_we_off",  32'(dmem_we), 32'd0);
    chk("sw_pc",      32'(imem_addr), 32'd9);
    run(1);                                 // FETCH pc=10

    tick(); tick();
    alu_zero = 2'b10; alu_out = 8'd3;
    tick();
    chk("bezr_bwd",   32'(imem_addr), 32'd7);

    alu_zero = 2'b00;
    run(3);                                 // 7,8,9 -> 10
    chk("back_to_10", 32'(imem_addr), 32'd10);
    tick(); tick();
    alu_zero = 2'b01; alu_out = 8'd250;
    tick();
    chk("bezr_fwd_wrap", 32'(imem_addr), 32'd4);

    alu_zero = 2'b00;
    run(1);                                 // 4 -> 5
    repeat (4) tick();                      // lw -> 6
    run(4);                                 // 6..9 -> 10
    chk("again_10",   32'(imem_addr), 32'd10);
    tick(); tick();
    alu_zero = 2'b00; alu_out = 8'd250;
    tick();
    chk("bezr_none",  32'(imem_addr), 32'd11);

    tick(); tick();                         // EXEC mov r5
    chk("mov_rf_we",  32'(rf_we), 32'd1);
    chk("mov_acc_we", 32'(acc_we), 32'd0);
    chk("mov_idx",    32'(rf_idx), 32'd5);
    tick();                                 // FETCH pc=12

    tick(); tick();
    alu_zero = 2'b01; alu_out = 8'd0;
    tick();
    chk("bezr_self",  32'(imem_addr), 32'd12);
    tick(); tick();
    alu_zero = 2'b11; alu_out = 8'd5;
    tick();
    chk("bezr_z11",   32'(imem_addr), 32'd13);
    alu_zero = 2'b00;

    tick(); tick();                         // EXEC sw at 13
    chk("sw2_we",     32'(dmem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we",    32'(dmem_we), 32'd0);
    chk("arst_state", 32'(dut.state_q), 32'(IDLE));
    chk("arst_pc",    32'(imem_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    mem[2] = 9'b0_0010_0000;                // halt
    start = 1'b1;
    tick();
    start = 1'b0;
    run(2);                                 // FETCH pc=2
    chk("halt_pc",    32'(imem_addr), 32'd2);
    tick(); tick();
    chk("halt_exec",  32'(halted), 32'd0);
    tick();
    chk("halted",     32'(halted), 32'd1);
    chk("halt_addr",  32'(imem_addr), 32'd2);
    start = 1'b1;
    tick(); tick();
    chk("halt_start_ign", 32'(dut.state_q), 32'(HALT));
    chk("halt_hold",  32'(halted), 32'd1);
    chk("halt_addr2", 32'(imem_addr), 32'd2);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("halt_rst",   32'(halted), 32'd0);
    chk("halt_rst_pc", 32'(imem_addr), 32'd0);
    chk("halt_rst_st", 32'(dut.state_q), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
